// File: rtl/vec_tile_buffer.sv
// ---------------------------------------------------------------------------
// vec_tile_buffer
//
// On-chip vector buffer that sits directly behind the DRAM vector loader.
// Whole tiles arriving on the loader's tile strobe are stored into one of
// NUM_BUFS vector slots, and the number of tiles committed to each slot is
// recorded. A slot can later be replayed tile-by-tile to the compute stage
// over a valid/ready stream. The write and read sides run independently on
// dual-port storage, so a slot can be filled while another is replayed.
//
// Ports
//   clk            clock, rising edge
//   rst            asynchronous, active-high reset
//   i_wr_start     open a write session to slot i_wr_buf_id
//   i_wr_buf_id    target slot, sampled on i_wr_start
//   i_wr_tile_vld  one tile present on i_wr_data
//   i_wr_data      tile as an unpacked array of ELEM_COUNT elements
//   i_wr_last      end of transfer (may coincide with the final tile)
//   o_wr_busy      write session open
//   o_wr_done      one-cycle pulse, session committed
//   o_wr_overflow  sticky for the session: a tile was dropped, slot full
//   i_rd_start     request replay of slot i_rd_buf_id (ignored while busy)
//   i_rd_buf_id    source slot, sampled on i_rd_start
//   o_rd_busy      replay in progress
//   o_rd_valid     o_rd_data holds a tile
//   i_rd_ready     consumer accepts the tile when o_rd_valid & i_rd_ready
//   o_rd_data      registered tile, unpacked array of ELEM_COUNT elements
//   o_rd_last      qualifies the final tile of the replay
//   o_rd_done      one-cycle pulse, replay finished
// ---------------------------------------------------------------------------
module vec_tile_buffer #(
    parameter int TILE_WIDTH    = 256,
    parameter int DATA_WIDTH    = 8,
    parameter int NUM_BUFS      = 8,
    parameter int TILES_PER_BUF = 32,
    localparam int ELEM_COUNT   = TILE_WIDTH / DATA_WIDTH,
    localparam int BID_W        = (NUM_BUFS > 1) ? $clog2(NUM_BUFS) : 1,
    localparam int CNT_W        = $clog2(TILES_PER_BUF + 1)
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  i_wr_start,
    input  logic [BID_W-1:0]      i_wr_buf_id,
    input  logic                  i_wr_tile_vld,
    input  logic [DATA_WIDTH-1:0] i_wr_data [ELEM_COUNT],
    input  logic                  i_wr_last,
    output logic                  o_wr_busy,
    output logic                  o_wr_done,
    output logic                  o_wr_overflow,

    input  logic                  i_rd_start,
    input  logic [BID_W-1:0]      i_rd_buf_id,
    output logic                  o_rd_busy,
    output logic                  o_rd_valid,
    input  logic                  i_rd_ready,
    output logic [DATA_WIDTH-1:0] o_rd_data [ELEM_COUNT],
    output logic                  o_rd_last,
    output logic                  o_rd_done
);

    localparam int DEPTH  = NUM_BUFS * TILES_PER_BUF;
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        W_IDLE,
        W_ACTIVE
    } wrState_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_FETCH,
        R_PRESENT,
        R_DONE
    } rdState_t;

    // Tile storage, one row per (slot, tile index). Contents survive reset.
    logic [TILE_WIDTH-1:0] r_mem [DEPTH];

    // Committed tile count per slot.
    logic [CNT_W-1:0]      r_slotCnt [NUM_BUFS];

    // Write side state
    wrState_t              r_wrState;
    logic [BID_W-1:0]      r_wrSlot;
    logic [CNT_W-1:0]      r_wrPtr;
    logic                  r_wrBusy;
    logic                  r_wrDone;
    logic                  r_wrOverflow;

    // Read side state
    rdState_t              r_rdState;
    logic [BID_W-1:0]      r_rdSlot;
    logic [CNT_W-1:0]      r_rdPtr;
    logic [CNT_W-1:0]      r_rdCnt;
    logic                  r_rdBusy;
    logic                  r_rdValid;
    logic                  r_rdLast;
    logic                  r_rdDone;
    logic [TILE_WIDTH-1:0] r_rdData;

    // Combinational helpers
    logic [TILE_WIDTH-1:0] w_wrDataPacked;
    logic                  w_wrRoom;
    logic                  w_wrAccept;
    logic [CNT_W-1:0]      w_wrPtrNext;
    logic [ADDR_W-1:0]     w_wrAddr;
    logic [ADDR_W-1:0]     w_rdAddr;

    // Flatten the incoming element array into one storage word; element 0
    // lands in the least significant bits.
    always_comb begin
        w_wrDataPacked = '0;
        for (int e = 0; e < ELEM_COUNT; e++) begin
            w_wrDataPacked[e*DATA_WIDTH +: DATA_WIDTH] = i_wr_data[e];
        end
    end

    // A tile is stored only inside an open session, while the slot still has
    // room, and not on a cycle where a new wr_start restarts the session.
    // w_wrPtrNext includes a tile stored this same cycle so that a wr_last
    // coinciding with the final tile commits the full count.
    assign w_wrRoom    = (r_wrPtr < CNT_W'(TILES_PER_BUF));
    assign w_wrAccept  = (r_wrState == W_ACTIVE) && !i_wr_start &&
                         i_wr_tile_vld && w_wrRoom;
    assign w_wrPtrNext = r_wrPtr + CNT_W'(w_wrAccept);

    // Slots are laid out back to back; the pointer never exceeds the slot
    // size, so an address never spills into the neighbouring slot.
    assign w_wrAddr = ADDR_W'(r_wrSlot) * ADDR_W'(TILES_PER_BUF) + ADDR_W'(r_wrPtr);
    assign w_rdAddr = ADDR_W'(r_rdSlot) * ADDR_W'(TILES_PER_BUF) + ADDR_W'(r_rdPtr);

    // Storage write port. Kept free of reset so it maps onto RAM; a read of
    // the same row in the same cycle sees the old contents.
    always_ff @(posedge clk) begin
        if (w_wrAccept) begin
            r_mem[w_wrAddr] <= w_wrDataPacked;
        end
    end

    // Write session FSM. A wr_start in any state (re)opens a session: the
    // slot is latched and its count cleared immediately, so an abandoned or
    // reset session leaves that slot reading as empty. Tiles beyond the slot
    // size are dropped and flagged; wr_last commits the count and pulses
    // wr_done on the following cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrState    <= W_IDLE;
            r_wrSlot     <= '0;
            r_wrPtr      <= '0;
            r_wrBusy     <= 1'b0;
            r_wrDone     <= 1'b0;
            r_wrOverflow <= 1'b0;
            for (int b = 0; b < NUM_BUFS; b++) begin
                r_slotCnt[b] <= '0;
            end
        end else begin
            r_wrDone <= 1'b0;
            case (r_wrState)
                W_IDLE: begin
                    if (i_wr_start) begin
                        r_wrSlot               <= i_wr_buf_id;
                        r_wrPtr                <= '0;
                        r_wrOverflow           <= 1'b0;
                        r_slotCnt[i_wr_buf_id] <= '0;
                        r_wrBusy               <= 1'b1;
                        r_wrState              <= W_ACTIVE;
                    end
                end
                W_ACTIVE: begin
                    if (i_wr_start) begin
                        r_wrSlot               <= i_wr_buf_id;
                        r_wrPtr                <= '0;
                        r_wrOverflow           <= 1'b0;
                        r_slotCnt[i_wr_buf_id] <= '0;
                        r_wrBusy               <= 1'b1;
                        r_wrState              <= W_ACTIVE;
                    end else begin
                        if (i_wr_tile_vld) begin
                            if (w_wrRoom) begin
                                r_wrPtr <= w_wrPtrNext;
                            end else begin
                                r_wrOverflow <= 1'b1;
                            end
                        end
                        if (i_wr_last) begin
                            r_slotCnt[r_wrSlot] <= w_wrPtrNext;
                            r_wrDone            <= 1'b1;
                            r_wrBusy            <= 1'b0;
                            r_wrState           <= W_IDLE;
                        end
                    end
                end
                default: begin
                    r_wrState <= W_IDLE;
                    r_wrBusy  <= 1'b0;
                end
            endcase
        end
    end

    // Replay FSM. The slot count is snapshotted on entry so a concurrent
    // write session cannot change the replay length. Each tile takes a fetch
    // cycle (synchronous read straight into the registered output) and a
    // present cycle that holds until the consumer accepts it, so the first
    // tile is valid two cycles after rd_start. An empty slot skips straight
    // to the done pulse without presenting anything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdState <= R_IDLE;
            r_rdSlot  <= '0;
            r_rdPtr   <= '0;
            r_rdCnt   <= '0;
            r_rdBusy  <= 1'b0;
            r_rdValid <= 1'b0;
            r_rdLast  <= 1'b0;
            r_rdDone  <= 1'b0;
            r_rdData  <= '0;
        end else begin
            r_rdDone <= 1'b0;
            case (r_rdState)
                R_IDLE: begin
                    if (i_rd_start) begin
                        r_rdSlot <= i_rd_buf_id;
                        r_rdCnt  <= r_slotCnt[i_rd_buf_id];
                        r_rdPtr  <= '0;
                        r_rdBusy <= 1'b1;
                        if (r_slotCnt[i_rd_buf_id] == '0) begin
                            r_rdState <= R_DONE;
                        end else begin
                            r_rdState <= R_FETCH;
                        end
                    end
                end
                R_FETCH: begin
                    r_rdData  <= r_mem[w_rdAddr];
                    r_rdValid <= 1'b1;
                    r_rdLast  <= (r_rdPtr == (r_rdCnt - CNT_W'(1)));
                    r_rdState <= R_PRESENT;
                end
                R_PRESENT: begin
                    if (i_rd_ready) begin
                        r_rdValid <= 1'b0;
                        r_rdLast  <= 1'b0;
                        r_rdPtr   <= r_rdPtr + CNT_W'(1);
                        if (r_rdLast) begin
                            r_rdState <= R_DONE;
                        end else begin
                            r_rdState <= R_FETCH;
                        end
                    end
                end
                R_DONE: begin
                    r_rdDone  <= 1'b1;
                    r_rdBusy  <= 1'b0;
                    r_rdState <= R_IDLE;
                end
                default: begin
                    r_rdState <= R_IDLE;
                    r_rdBusy  <= 1'b0;
                    r_rdValid <= 1'b0;
                    r_rdLast  <= 1'b0;
                end
            endcase
        end
    end

    // Split the registered output word back into the element array.
    always_comb begin
        for (int e = 0; e < ELEM_COUNT; e++) begin
            o_rd_data[e] = r_rdData[e*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign o_wr_busy     = r_wrBusy;
    assign o_wr_done     = r_wrDone;
    assign o_wr_overflow = r_wrOverflow;
    assign o_rd_busy     = r_rdBusy;
    assign o_rd_valid    = r_rdValid;
    assign o_rd_last     = r_rdLast;
    assign o_rd_done     = r_rdDone;

endmodule

// File: tb/tb_vec_tile_buffer.sv
// ---------------------------------------------------------------------------
// tb_vec_tile_buffer
//
// Directed bench for vec_tile_buffer with default parameters (256-bit tiles,
// 8-bit elements, 8 slots of 32 tiles). Tile contents come from a simple
// generator; the bench keeps its own copy of what each slot should hold and
// how many tiles each slot should report, and checks every replayed tile
// against that copy.
// ---------------------------------------------------------------------------
module tb_vec_tile_buffer;

    localparam int TW   = 256;
    localparam int DW   = 8;
    localparam int EC   = TW / DW;
    localparam int NB   = 8;
    localparam int TPB  = 32;

    logic          clk;
    logic          rst;
    logic          wrStart;
    logic [2:0]    wrBufId;
    logic          wrTileVld;
    logic [DW-1:0] wrData [EC];
    logic          wrLast;
    logic          wrBusy;
    logic          wrDone;
    logic          wrOverflow;
    logic          rdStart;
    logic [2:0]    rdBufId;
    logic          rdBusy;
    logic          rdValid;
    logic          rdReady;
    logic [DW-1:0] rdData [EC];
    logic          rdLast;
    logic          rdDone;

    logic [TW-1:0] rdDataPacked;

    // Expected slot contents and counts
    logic [TW-1:0] expMem [NB][TPB];
    int            expCnt [NB];

    int testsRun;
    int testsFailed;

    vec_tile_buffer dut (
        .clk           (clk),
        .rst           (rst),
        .i_wr_start    (wrStart),
        .i_wr_buf_id   (wrBufId),
        .i_wr_tile_vld (wrTileVld),
        .i_wr_data     (wrData),
        .i_wr_last     (wrLast),
        .o_wr_busy     (wrBusy),
        .o_wr_done     (wrDone),
        .o_wr_overflow (wrOverflow),
        .i_rd_start    (rdStart),
        .i_rd_buf_id   (rdBufId),
        .o_rd_busy     (rdBusy),
        .o_rd_valid    (rdValid),
        .i_rd_ready    (rdReady),
        .o_rd_data     (rdData),
        .o_rd_last     (rdLast),
        .o_rd_done     (rdDone)
    );

    // 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Flatten the DUT output array for whole-tile comparisons
    always_comb begin
        rdDataPacked = '0;
        for (int i = 0; i < EC; i++) begin
            rdDataPacked[i*DW +: DW] = rdData[i];
        end
    end

    // Hard stop in case the DUT wedges somewhere not covered by a bound
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got no completion, required finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single point of comparison: count it, report a mismatch
    task automatic checkOutput(input string tag, input logic [TW-1:0] observed,
                               input logic [TW-1:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Advance one clock and settle just past the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Tile k for a given seed: element i = seed + k*32 + i (mod 256)
    function automatic logic [TW-1:0] makeTile(input logic [7:0] seed, input int k);
        logic [TW-1:0] t;
        t = '0;
        for (int i = 0; i < EC; i++) begin
            t[i*DW +: DW] = seed + 8'(k * EC + i);
        end
        return t;
    endfunction

    task automatic applyStimulus(input logic [TW-1:0] tile);
        for (int i = 0; i < EC; i++) begin
            wrData[i] = tile[i*DW +: DW];
        end
    endtask

    // Full write session of n tiles, wr_last together with the final tile
    task automatic writeSlot(input int slot, input int n, input logic [7:0] seed);
        logic [TW-1:0] tile;
        wrStart = 1'b1;
        wrBufId = 3'(slot);
        tick();
        wrStart = 1'b0;
        checkOutput("wrBusyOpen", 256'(wrBusy), 256'(1'b1));
        for (int k = 0; k < n; k++) begin
            tile = makeTile(seed, k);
            applyStimulus(tile);
            wrTileVld = 1'b1;
            wrLast    = (k == n - 1);
            if (k < TPB) begin
                expMem[slot][k] = tile;
            end
            tick();
        end
        wrTileVld = 1'b0;
        wrLast    = 1'b0;
        expCnt[slot] = (n > TPB) ? TPB : n;
        checkOutput("wrDone", 256'(wrDone), 256'(1'b1));
        checkOutput("wrOverflow", 256'(wrOverflow), 256'(n > TPB));
        tick();
        checkOutput("wrDonePulse", 256'(wrDone), 256'(1'b0));
        checkOutput("wrBusyClosed", 256'(wrBusy), 256'(1'b0));
    endtask

    // Replay a slot and check every tile against the expected copy.
    // stallTile/stallCycles hold rd_ready low on one tile for a while.
    task automatic readSlot(input int slot, input int stallTile, input int stallCycles);
        int n;
        int got;
        int stallLeft;
        int firstValid;
        int doneCyc;
        int budget;
        n          = expCnt[slot];
        got        = 0;
        stallLeft  = stallCycles;
        firstValid = -1;
        doneCyc    = -1;
        budget     = 3 * n + stallCycles + 10;
        rdStart = 1'b1;
        rdBufId = 3'(slot);
        rdReady = 1'b0;
        tick();
        rdStart = 1'b0;
        checkOutput("rdBusyOpen", 256'(rdBusy), 256'(1'b1));
        for (int cyc = 1; cyc <= budget; cyc++) begin
            if (rdDone) begin
                doneCyc = cyc;
                break;
            end
            if (rdValid) begin
                if (firstValid < 0) begin
                    firstValid = cyc;
                end
                if (got >= n) begin
                    checkOutput("rdExtraTile", 256'(rdValid), 256'(1'b0));
                    rdReady = 1'b1;
                end else if (got == stallTile && stallLeft > 0) begin
                    rdReady = 1'b0;
                    checkOutput("rdHoldData", rdDataPacked, expMem[slot][got]);
                    checkOutput("rdHoldLast", 256'(rdLast), 256'(got == n - 1));
                    stallLeft--;
                end else begin
                    rdReady = 1'b1;
                    checkOutput("rdData", rdDataPacked, expMem[slot][got]);
                    checkOutput("rdLast", 256'(rdLast), 256'(got == n - 1));
                    got++;
                end
            end else begin
                if (stallLeft > 0 && stallLeft < stallCycles) begin
                    checkOutput("rdHoldValid", 256'(rdValid), 256'(1'b1));
                end
                rdReady = 1'b1;
            end
            tick();
        end
        rdReady = 1'b0;
        checkOutput("rdTileCount", 256'(got), 256'(n));
        checkOutput("rdDoneSeen", 256'(doneCyc > 0), 256'(1'b1));
        if (n == 0) begin
            checkOutput("rdEmptyDoneCycle", 256'(doneCyc), 256'(2));
            checkOutput("rdEmptyNoValid", 256'(firstValid < 0), 256'(1'b1));
        end else begin
            checkOutput("rdFirstValidCycle", 256'(firstValid), 256'(2));
        end
        tick();
        checkOutput("rdDonePulse", 256'(rdDone), 256'(1'b0));
        checkOutput("rdBusyClosed", 256'(rdBusy), 256'(1'b0));
    endtask

    // Every output must sit at its reset value
    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_wrBusy"}, 256'(wrBusy), 256'(1'b0));
        checkOutput({tag, "_wrDone"}, 256'(wrDone), 256'(1'b0));
        checkOutput({tag, "_wrOverflow"}, 256'(wrOverflow), 256'(1'b0));
        checkOutput({tag, "_rdBusy"}, 256'(rdBusy), 256'(1'b0));
        checkOutput({tag, "_rdValid"}, 256'(rdValid), 256'(1'b0));
        checkOutput({tag, "_rdLast"}, 256'(rdLast), 256'(1'b0));
        checkOutput({tag, "_rdDone"}, 256'(rdDone), 256'(1'b0));
        checkOutput({tag, "_rdData"}, rdDataPacked, 256'(0));
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        rst       = 1'b1;
        wrStart   = 1'b0;
        wrBufId   = '0;
        wrTileVld = 1'b0;
        wrLast    = 1'b0;
        rdStart   = 1'b0;
        rdBufId   = '0;
        rdReady   = 1'b0;
        applyStimulus('0);
        for (int s = 0; s < NB; s++) begin
            expCnt[s] = 0;
        end

        // Power-on reset
        tick();
        tick();
        checkIdleOutputs("reset");
        rst = 1'b0;
        tick();

        // Slot 2, four tiles, straight replay then a stalled replay
        writeSlot(2, 4, 8'h00);
        readSlot(2, -1, 0);
        readSlot(2, 1, 5);

        // Slot 0 overfilled with 34 tiles: only 32 kept
        writeSlot(0, 34, 8'h40);
        readSlot(0, -1, 0);

        // Never-written slot replays as empty
        readSlot(5, -1, 0);

        // Concurrent write of slot 1 during replay of slot 3
        writeSlot(3, 5, 8'hA5);
        fork
            writeSlot(1, 6, 8'h80);
            readSlot(3, -1, 0);
        join
        readSlot(1, -1, 0);

        // Reset in the middle of a write to slot 4 and a replay of slot 2
        wrStart = 1'b1;
        wrBufId = 3'd4;
        rdStart = 1'b1;
        rdBufId = 3'd2;
        rdReady = 1'b1;
        tick();
        wrStart = 1'b0;
        rdStart = 1'b0;
        for (int k = 0; k < 2; k++) begin
            applyStimulus(makeTile(8'h11, k));
            wrTileVld = 1'b1;
            tick();
        end
        applyStimulus(makeTile(8'h11, 2));
        rst = 1'b1;
        tick();
        checkIdleOutputs("midReset");
        rst       = 1'b0;
        wrTileVld = 1'b0;
        rdReady   = 1'b0;
        for (int s = 0; s < NB; s++) begin
            expCnt[s] = 0;
        end
        tick();
        checkOutput("postResetWrDone", 256'(wrDone), 256'(1'b0));
        checkOutput("postResetRdDone", 256'(rdDone), 256'(1'b0));
        readSlot(2, -1, 0);
        readSlot(4, -1, 0);

        // Fresh sessions after the reset
        writeSlot(4, 3, 8'h11);
        readSlot(4, -1, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
